ens_vote_argmax: RTL and testbench
==================================

// Module: ens_vote_argmax
// PURPOSE
//  Output stage downstream of the last generated LUT layer of every ensemble member.
//  Captures all members' final class codes in one handshake and sums them per class,
//  one member per cycle. Then scans the sums, one class per cycle, and presents the
//  winning class index and its score on a valid/ready output.
//  Replaces a wide combinational adder/comparator tree with a small FSM, so the
//  logicnet pipeline keeps its clock.
// PARAMETERS
//  NUM_ENS   4   number of ensemble members (>=1)
//  CLASSES   10  number of classes per member (>=2)
//  OUT_BITS  2   width of one class code from a member's last layer (unsigned)
//  derived: IDX_W = $clog2(CLASSES); SUM_W = OUT_BITS + $clog2(NUM_ENS)
// PORTS
//  clk        in   1                          single clock, rising edge
//  rst        in   1                          synchronous, active-high reset
//  in_valid   in   1                          in_data holds a complete ensemble result
//  in_ready   out  1                          block can capture in_data this cycle
//  in_data    in   NUM_ENS*CLASSES*OUT_BITS   member m, class c at [(m*CLASSES+c)*OUT_BITS +: OUT_BITS]
//  out_valid  out  1                          out_class/out_score hold a result
//  out_ready  in   1                          consumer accepts the result
//  out_class  out  IDX_W                      argmax class index
//  out_score  out  SUM_W                      summed score of out_class
// BEHAVIOUR
//  - One clock and reset as fixed above. All state changes on the rising edge of clk.
//  - Reset: state=IDLE, in_ready=1, out_valid=0, out_class=0, out_score=0,
//    all sums, counters and the capture buffer cleared.
//  - Reset mid-operation abandons the current job: no output is produced, and in_ready=1
//    in the cycle after reset deasserts.
//  - FSM states: IDLE, ACCUM, SCAN, DONE.
//  - IDLE: in_ready=1.
//    - in_valid=1 at an edge: capture in_data into the buffer, clear sums, m=0, go to ACCUM.
//  - ACCUM: in_ready=0. Each edge adds member m's CLASSES codes to the per-class sums.
//    - m counts 0..NUM_ENS-1. After m=NUM_ENS-1, go to SCAN with c=0, best=0, best_score=0.
//  - SCAN: each edge compares sum[c] with best_score.
//    - Strictly greater replaces best/best_score. Ties keep the lower index.
//    - c=0 always loads (best=0, best_score=sum[0]).
//    - After c=CLASSES-1, register out_class=best and out_score=best_score, go to DONE.
//  - DONE: out_valid=1. out_class and out_score are stable while out_valid=1 && out_ready=0.
//    - out_valid=1 && out_ready=1 at an edge: out_valid=0, go to IDLE.
//      in_ready is high in the following cycle; there is no same-cycle bypass into the next job.
//  - Latency: out_valid rises NUM_ENS+CLASSES cycles after the capture edge.
//    - Minimum accept-to-accept period is NUM_ENS+CLASSES+2 cycles.
//  - in_data is sampled only at the capture edge. Changes afterwards have no effect.
//  - Arithmetic is unsigned. SUM_W is sized so that NUM_ENS*(2^OUT_BITS-1) never overflows,
//    so no saturation or wrap is needed.
//  - out_class and out_score change only on entry to DONE. They hold their last values
//    through IDLE/ACCUM/SCAN and are 0 after reset.
//  - in_valid while not in IDLE is ignored: in_ready=0, so the producer must hold.
//  - out_ready outside DONE is ignored.
// TESTING
//  1. Reset then idle: out_valid=0, in_ready=1, out_class=0, out_score=0 for 20 cycles.
//  2. Defaults; all members give class 7 code 3, all other codes 0:
//     out_valid exactly 14 cycles after capture, out_class=7, out_score=12.
//  3. Tie: sum[2]=sum[5]=6, all other sums lower -> out_class=2, out_score=6.
//     All codes 0 -> out_class=0, out_score=0.
//  4. Backpressure: hold out_ready=0 for 10 cycles in DONE: outputs stable, in_ready=0.
//     Raise out_ready: out_valid drops next edge, in_ready=1 in the cycle after that.
//  5. Reset asserted on the 3rd ACCUM cycle: out_valid never rises for that job.
//     A fresh job with class 4 code 3 from all members then yields out_class=4, out_score=12.
//  6. Randomised back-to-back jobs with in_valid held high, checked against a reference
//     argmax (lowest-index tie break). Also NUM_ENS=1/CLASSES=2 and NUM_ENS=5/OUT_BITS=3
//     builds: max-code inputs give out_score=2^OUT_BITS-1 and 35 respectively, no overflow.

Source files
------------

// File: rtl/ens_vote_argmax.sv
// ens_vote_argmax: captures all ensemble members' class codes, sums them
// one member per cycle, then scans one class per cycle for the argmax.
module ens_vote_argmax #(
  parameter int NUM_ENS  = 4,
  parameter int CLASSES  = 10,
  parameter int OUT_BITS = 2,
  localparam int IDX_W = $clog2(CLASSES),
  localparam int SUM_W = OUT_BITS + $clog2(NUM_ENS),
  localparam int IN_W  = NUM_ENS*CLASSES*OUT_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_class,
  output logic [SUM_W-1:0] out_score
);

  localparam int M_W = (NUM_ENS > 1) ? $clog2(NUM_ENS) : 1;

  typedef enum logic [1:0] {
    IDLE, ACCUM, SCAN, DONE
  } state_t;

  state_t state, state_nx;

  logic [IN_W-1:0]  cap;
  logic [SUM_W-1:0] sum [CLASSES];
  logic [M_W-1:0]   m;
  logic [IDX_W-1:0] c, best, best_nx;
  logic [SUM_W-1:0] best_score, score_nx;
  logic             m_last, c_last, take;

  assign m_last = (m == M_W'(NUM_ENS-1));
  assign c_last = (c == IDX_W'(CLASSES-1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nx = ACCUM;
      ACCUM:   if (m_last)    state_nx = SCAN;
      SCAN:    if (c_last)    state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // c=0 always loads; strict > keeps the lower index on ties
  always_comb begin
    take     = (c == '0) || (sum[c] > best_score);
    best_nx  = take ? c : best;
    score_nx = take ? sum[c] : best_score;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap        <= '0;
      m          <= '0;
      c          <= '0;
      best       <= '0;
      best_score <= '0;
      out_class  <= '0;
      out_score  <= '0;
      for (int i = 0; i < CLASSES; i++) sum[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            cap <= in_data;
            m   <= '0;
            for (int i = 0; i < CLASSES; i++) sum[i] <= '0;
          end
        end
        ACCUM: begin
          for (int i = 0; i < CLASSES; i++)
            sum[i] <= sum[i] + SUM_W'(
              cap[(int'(m)*CLASSES+i)*OUT_BITS +: OUT_BITS]);
          m          <= m + M_W'(1);
          c          <= '0;
          best       <= '0;
          best_score <= '0;
        end
        SCAN: begin
          c          <= c + IDX_W'(1);
          best       <= best_nx;
          best_score <= score_nx;
          if (c_last) begin
            out_class <= best_nx;
            out_score <= score_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ens_vote_argmax.sv
// tb_ens_vote_argmax: directed and randomised checks of the ensemble
// vote/argmax stage against a plain-arithmetic reference model.
module tb_ens_vote_argmax;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv = 1'b0, ir, ov, ordy = 1'b0;
  logic [79:0] idata = '0;
  logic [3:0]  ocls, oscr;

  logic        ivb = 1'b0, irb, ovb, orb = 1'b1;
  logic [3:0]  idb = '0;
  logic [0:0]  ocb;
  logic [1:0]  osb;

  logic        ivc = 1'b0, irc, ovc, orc = 1'b1;
  logic [149:0] idc = '0;
  logic [3:0]  occ;
  logic [5:0]  osc;

  ens_vote_argmax dut (
    .clk(clk), .rst(rst),
    .in_valid(iv), .in_ready(ir), .in_data(idata),
    .out_valid(ov), .out_ready(ordy),
    .out_class(ocls), .out_score(oscr)
  );

  ens_vote_argmax #(.NUM_ENS(1), .CLASSES(2), .OUT_BITS(2)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(ivb), .in_ready(irb), .in_data(idb),
    .out_valid(ovb), .out_ready(orb),
    .out_class(ocb), .out_score(osb)
  );

  ens_vote_argmax #(.NUM_ENS(5), .CLASSES(10), .OUT_BITS(3)) dut_c (
    .clk(clk), .rst(rst),
    .in_valid(ivc), .in_ready(irc), .in_data(idc),
    .out_valid(ovc), .out_ready(orc),
    .out_class(occ), .out_score(osc)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cd [4][10];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_one(input int k, input int code);
    foreach (cd[m, c]) cd[m][c] = (c == k) ? code : 0;
  endtask

  function automatic logic [79:0] pack_cd();
    logic [79:0] d;
    d = '0;
    foreach (cd[m, c]) d[(m*10+c)*2 +: 2] = 2'(cd[m][c]);
    return d;
  endfunction

  // Reference: per-class totals, first maximum wins
  task automatic ref_am(output int cls, output int sc);
    int s;
    cls = 0;
    sc  = -1;
    for (int c = 0; c < 10; c++) begin
      s = 0;
      for (int m = 0; m < 4; m++) s += cd[m][c];
      if (s > sc) begin
        sc  = s;
        cls = c;
      end
    end
  endtask

  task automatic do_job(input string tag, input bit hold,
                        output int cls, output int sc);
    int k;
    ref_am(cls, sc);
    idata = pack_cd();
    iv    = 1'b1;
    chk({tag, "_in_ready"}, 32'(ir), 1);
    step();
    if (!hold) iv = 1'b0;
    idata = 80'({$urandom, $urandom, $urandom});
    chk({tag, "_busy"}, 32'(ir), 0);
    k = 0;
    while (!ov && k < 40) begin
      step();
      k++;
    end
    chk({tag, "_latency"}, k, 14);
    chk({tag, "_class"}, 32'(ocls), cls);
    chk({tag, "_score"}, 32'(oscr), sc);
  endtask

  task automatic accept(input string tag);
    ordy = 1'b1;
    step();
    ordy = 1'b0;
    chk({tag, "_ov_drop"}, 32'(ov), 0);
    chk({tag, "_ir_back"}, 32'(ir), 1);
  endtask

  initial begin
    int cls, sc, k;
    bit seen;

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("rst_ov", 32'(ov), 0);
      chk("rst_ir", 32'(ir), 1);
      chk("rst_cls", 32'(ocls), 0);
      chk("rst_scr", 32'(oscr), 0);
      step();
    end

    set_one(7, 3);
    do_job("cls7", 1'b0, cls, sc);
    chk("cls7_abs_class", 32'(ocls), 7);
    chk("cls7_abs_score", 32'(oscr), 12);
    accept("cls7");

    set_one(0, 0);
    for (int m = 0; m < 3; m++) begin
      cd[m][2] = 2;
      cd[m][5] = 2;
    end
    cd[3][9] = 3;
    cd[0][0] = 1;
    do_job("tie", 1'b0, cls, sc);
    chk("tie_abs_class", 32'(ocls), 2);
    chk("tie_abs_score", 32'(oscr), 6);
    accept("tie");

    set_one(0, 0);
    do_job("zero", 1'b0, cls, sc);
    chk("zero_abs_class", 32'(ocls), 0);
    accept("zero");

    foreach (cd[m, c]) cd[m][c] = int'($urandom_range(0, 3));
    do_job("bp", 1'b0, cls, sc);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_ov", 32'(ov), 1);
      chk("bp_ir", 32'(ir), 0);
      chk("bp_cls", 32'(ocls), cls);
      chk("bp_scr", 32'(oscr), sc);
    end
    accept("bp");

    set_one(4, 2);
    idata = pack_cd();
    iv = 1'b1;
    step();
    iv = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ir", 32'(ir), 1);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (ov) seen = 1'b1;
      step();
    end
    chk("mid_rst_no_out", 32'(seen), 0);
    set_one(4, 3);
    do_job("fresh", 1'b0, cls, sc);
    chk("fresh_abs_class", 32'(ocls), 4);
    chk("fresh_abs_score", 32'(oscr), 12);
    accept("fresh");

    ordy = 1'b1;
    for (int j = 0; j < 8; j++) begin
      foreach (cd[m, c]) cd[m][c] = int'($urandom_range(0, 3));
      do_job($sformatf("rnd%0d", j), 1'b1, cls, sc);
      step();
    end
    iv = 1'b0;
    ordy = 1'b0;
    step();
    chk("rnd_idle_ov", 32'(ov), 0);

    idb = '1;
    ivb = 1'b1;
    step();
    ivb = 1'b0;
    k = 0;
    while (!ovb && k < 40) begin
      step();
      k++;
    end
    chk("b_latency", k, 3);
    chk("b_class", 32'(ocb), 0);
    chk("b_score", 32'(osb), 3);

    idc = '1;
    ivc = 1'b1;
    step();
    ivc = 1'b0;
    k = 0;
    while (!ovc && k < 40) begin
      step();
      k++;
    end
    chk("c_latency", k, 15);
    chk("c_class", 32'(occ), 0);
    chk("c_score", 32'(osc), 35);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
